// File: rtl/fan_speed_ctrl.sv
// Temperature-driven fan level selector feeding flex_counter_if; steps one level at a time with a dwell between steps.
// Optional downward hysteresis is enabled by defining FAN_HYST_EN.
module fan_speed_ctrl #(
    parameter logic [7:0]  T_LOW        = 8'd40,
    parameter logic [7:0]  T_MED        = 8'd60,
    parameter logic [7:0]  T_HIGH       = 8'd80,
    parameter logic [7:0]  HYST         = 8'd4,
    parameter int unsigned DWELL_CYCLES = 16,
    parameter logic [6:0]  ROLL_1       = 7'd30,
    parameter logic [6:0]  ROLL_2       = 7'd60,
    parameter logic [6:0]  ROLL_3       = 7'd90
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       temp_valid,
    input  logic [7:0] temp_data,
    output logic       temp_ready,
    output logic [1:0] fan_speed,
    output logic [6:0] rollover_val,
    output logic       sign,
    output logic       speed_change
);

    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

    // With hysteresis off the margin collapses to zero, making down and up thresholds identical.
`ifdef FAN_HYST_EN
    localparam logic [7:0] HYST_EFF = HYST;
`else
    localparam logic [7:0] HYST_EFF = HYST & 8'd0;
`endif
    localparam logic [7:0] D_LOW  = (T_LOW  >= HYST_EFF) ? 8'(T_LOW  - HYST_EFF) : 8'd0;
    localparam logic [7:0] D_MED  = (T_MED  >= HYST_EFF) ? 8'(T_MED  - HYST_EFF) : 8'd0;
    localparam logic [7:0] D_HIGH = (T_HIGH >= HYST_EFF) ? 8'(T_HIGH - HYST_EFF) : 8'd0;

    typedef enum logic [1:0] {IDLE, EVAL, STEP, DWELL} state_t;

    state_t          state;
    logic [7:0]      sample;
    logic [1:0]      target;
    logic [DW-1:0]   dwell;
    logic            pending;

    logic [1:0]      up_tgt_c;
    logic [1:0]      dn_tgt_c;
    logic [1:0]      target_c;
    logic [1:0]      lvl_nxt_c;
    logic            accept_c;

    function automatic logic [6:0] roll_of(input logic [1:0] lvl);
        case (lvl)
            2'd1:    roll_of = ROLL_1;
            2'd2:    roll_of = ROLL_2;
            2'd3:    roll_of = ROLL_3;
            default: roll_of = 7'd0;
        endcase
    endfunction

    // Target level: rising uses the raw thresholds, falling uses the (possibly lowered) ones.
    always_comb begin
        up_tgt_c = 2'd0;
        dn_tgt_c = 2'd0;
        if (sample >= T_HIGH)     up_tgt_c = 2'd3;
        else if (sample >= T_MED) up_tgt_c = 2'd2;
        else if (sample >= T_LOW) up_tgt_c = 2'd1;
        if (sample >= D_HIGH)     dn_tgt_c = 2'd3;
        else if (sample >= D_MED) dn_tgt_c = 2'd2;
        else if (sample >= D_LOW) dn_tgt_c = 2'd1;
        if (up_tgt_c >= fan_speed)     target_c = up_tgt_c;
        else if (dn_tgt_c < fan_speed) target_c = dn_tgt_c;
        else                           target_c = fan_speed;
        lvl_nxt_c = (target > fan_speed) ? 2'(fan_speed + 2'd1) : 2'(fan_speed - 2'd1);
        accept_c  = temp_valid && temp_ready;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            sample       <= 8'd0;
            target       <= 2'd0;
            dwell        <= '0;
            pending      <= 1'b0;
            temp_ready   <= 1'b1;
            fan_speed    <= 2'd0;
            rollover_val <= 7'd0;
            sign         <= 1'b1;
            speed_change <= 1'b0;
        end else begin
            speed_change <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sample     <= temp_data;
                        state      <= EVAL;
                        temp_ready <= 1'b0;
                    end
                end
                EVAL: begin
                    target <= target_c;
                    if (target_c != fan_speed) begin
                        state <= STEP;
                    end else begin
                        state      <= IDLE;
                        temp_ready <= 1'b1;
                    end
                end
                STEP: begin
                    fan_speed    <= lvl_nxt_c;
                    rollover_val <= roll_of(lvl_nxt_c);
                    sign         <= (target > fan_speed);
                    speed_change <= 1'b1;
                    dwell        <= DW'(DWELL_CYCLES);
                    state        <= DWELL;
                    temp_ready   <= 1'b1;
                end
                DWELL: begin
                    if (accept_c) sample <= temp_data;
                    // Counter hitting zero on this edge ends the dwell, giving DWELL_CYCLES+1 step spacing.
                    if (dwell <= DW'(1)) begin
                        dwell <= '0;
                        if (pending || accept_c) begin
                            pending    <= 1'b0;
                            state      <= EVAL;
                            temp_ready <= 1'b0;
                        end else if (target != fan_speed) begin
                            state      <= STEP;
                            temp_ready <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dwell <= DW'(dwell - DW'(1));
                        if (accept_c) pending <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    temp_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/fan_speed_ctrl.md
# fan_speed_ctrl

Closed-loop fan speed selector that sits directly upstream of `flex_counter`. It consumes 8-bit temperature samples over a valid/ready handshake and maps them to a fan level 0–3 with optional hysteresis. It moves one level at a time, with a minimum dwell between steps, and drives the `fan_speed`, `rollover_val` and `sign` fields of `flex_counter_if`.

## Interface
Parameters:
- `T_LOW`, default 8'd40: temperature at or above which level ≥1 is required.
- `T_MED`, default 8'd60: threshold for level ≥2.
- `T_HIGH`, default 8'd80: threshold for level 3.
- `HYST`, default 8'd4: downward hysteresis margin; used only with `FAN_HYST_EN`.
- `DWELL_CYCLES`, default 16: minimum cycles between two level steps (≥1).
- `ROLL_1`, `ROLL_2`, `ROLL_3`, defaults 7'd30, 7'd60, 7'd90: `rollover_val` for levels 1–3. Level 0 uses 7'd0.

Ports:
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `temp_valid` in 1: temperature sample valid.
- `temp_data` in 8: unsigned temperature sample.
- `temp_ready` out 1: block accepts a sample this cycle.
- `fan_speed` out 2: current fan level, to `flex_counter_if`.
- `rollover_val` out 7: counter rollover for the current level.
- `sign` out 1: direction of the last step; 1 = up, 0 = down.
- `speed_change` out 1: one-cycle pulse on the cycle after each level step.

## Operation
- States: IDLE, EVAL, STEP, DWELL.
- A sample is accepted when `temp_valid && temp_ready`. `temp_ready` = 1 in IDLE and DWELL, and 0 in EVAL and STEP.
- IDLE: on accept, register `temp_data` and go to EVAL.
- EVAL: compute the target from the registered sample and the current level.
  - Up-thresholds: ≥`T_HIGH` gives 3, ≥`T_MED` gives 2, ≥`T_LOW` gives 1, otherwise 0.
  - The target register is updated.
  - If target ≠ level, go to STEP. Otherwise go to IDLE.
- STEP: level moves ±1 toward the target.
  - `sign` = 1 if the step is up, 0 if down.
  - `rollover_val` = ROLL for the new level.
  - Dwell counter loads `DWELL_CYCLES`.
  - Go to DWELL.
- DWELL: the counter decrements each cycle.
  - An accepted sample overwrites the sample register and sets `pending`. A later sample overwrites an earlier one.
  - When the counter reaches 0: if `pending`, clear it and go to EVAL. Else if target ≠ level, go to STEP. Else go to IDLE.
- Steps are never larger than one level. Going from 0 to 3 takes three STEP visits separated by dwells.
- Threshold comparisons are unsigned 8-bit.
- With hysteresis, `T−HYST` saturates at 0 and cannot wrap.

## Timing
- Reset values: state IDLE, `fan_speed` 0, `rollover_val` 0, `sign` 1, `speed_change` 0, `temp_ready` 1, dwell counter 0, `pending` 0, target 0.
- Latency: accept at edge E0, EVAL during E0–E1, STEP during E1–E2. New `fan_speed`, `rollover_val` and `sign` are visible after E2, with `speed_change` high for exactly the cycle E2–E3.
- Consecutive steps are spaced exactly `DWELL_CYCLES`+1 cycles apart. Outputs stay constant between steps.
- If `temp_valid` is held high during EVAL or STEP, the sample is not taken and must be held by the source.
- Reset mid-DWELL or mid-STEP: all registers return to their reset values immediately. Any in-flight step is discarded.
- Samples equal to a threshold count as meeting it.

## Configuration
- `FAN_HYST_EN` defined: lowering below a level requires the sample to be < threshold − `HYST`.
  - Example: with level 2 and defaults, the target drops to 1 only when `temp_data` < 56.
  - Upward thresholds are unchanged.
- `FAN_HYST_EN` undefined: up and down thresholds are identical and the `HYST` parameter is unused.

## Test plan
- Reset, then one sample 8'd85 with defaults:
  - Level steps 0→1→2→3.
  - `rollover_val` goes 30, 60, 90 with `sign`=1.
  - Three `speed_change` pulses, 17 cycles apart.
  - First update appears 2 cycles after accept.
- At level 3, send a sample of 8'd10: three down steps to 0, `sign`=0, final `rollover_val`=0.
- With `FAN_HYST_EN`, at level 2, send 8'd58: no step and no `speed_change`. Then send 8'd55: one step to level 1.
- Without `FAN_HYST_EN`, at level 2, send 8'd58: step to level 1.
- During DWELL, send 8'd85 then 8'd20 back-to-back (both accepted): only 8'd20 is evaluated when the dwell ends.
- Assert `nRST` low mid-DWELL at level 2: all outputs return to their reset values asynchronously, and `temp_ready`=1 after release.
